// File: rtl/panel_pkg.sv
// Shared constants for the LED panel column-scan path.
// Select-code width, blanking code and default panel geometry.
package panel_pkg;

    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] BLANK_SEL = 3'b111;

    localparam int NUM_COLS_DEF = 5;
    localparam int NUM_ROWS_DEF = 7;
    localparam int SCAN_DIV_DEF = 50000;
    localparam int BLANK_CYCLES_DEF = 4;

    localparam int FRAME_W_DEF = NUM_COLS_DEF * NUM_ROWS_DEF;

endpackage

// File: rtl/scan_timebase.sv
// Column slot timebase: divider, scan index, blanking and
// frame-wrap strobe, plus look-ahead values for registered outputs.
module scan_timebase
    import panel_pkg::*;
#(
    parameter int NUM_COLS     = NUM_COLS_DEF,
    parameter int SCAN_DIV     = SCAN_DIV_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [SEL_W-1:0] nxt_idx,
    output logic             nxt_blank,
    output logic             blank,
    output logic             frame_wrap
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
    localparam logic [SEL_W-1:0] LAST_COL = SEL_W'(NUM_COLS - 1);

    logic [CW-1:0]    div_cnt;
    logic [CW-1:0]    nxt_cnt;
    logic [SEL_W-1:0] scan_idx;
    logic             wrap;

    always_comb begin
        wrap       = (div_cnt == LAST_CNT);
        frame_wrap = wrap && (scan_idx == LAST_COL);
        nxt_cnt    = wrap ? '0 : div_cnt + 1'b1;
        nxt_idx    = scan_idx;
        if (wrap) begin
            nxt_idx = (scan_idx == LAST_COL) ? '0 : scan_idx + 1'b1;
        end
        nxt_blank  = (nxt_cnt < BLANK_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            scan_idx <= '0;
            blank    <= 1'b1;
        end else begin
            div_cnt  <= nxt_cnt;
            scan_idx <= nxt_idx;
            blank    <= nxt_blank;
        end
    end

endmodule

// File: rtl/matrix_scan_controller.sv
// Column-scan sequencer for the 5x7 LED panel with a double-buffered
// frame, blanking gaps between columns and frame-boundary swaps.
module matrix_scan_controller
    import panel_pkg::*;
#(
    parameter int NUM_COLS     = NUM_COLS_DEF,
    parameter int NUM_ROWS     = NUM_ROWS_DEF,
    parameter int SCAN_DIV     = SCAN_DIV_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_COLS*NUM_ROWS-1:0] frame_data,
    input  logic                         frame_valid,
    output logic                         frame_ready,
    output logic [SEL_W-1:0]             scan_sel,
    output logic [NUM_ROWS-1:0]          line_data,
    output logic                         blank,
    output logic                         frame_start
);

    if (NUM_COLS < 2 || NUM_COLS > 7) begin : g_bad_cols
        $error("NUM_COLS must be in 2..7");
    end

    typedef logic [NUM_COLS-1:0][NUM_ROWS-1:0] frame_t;

    frame_t           active_q;
    frame_t           shadow_q;
    frame_t           active_nxt;
    logic [SEL_W-1:0] nxt_idx;
    logic             nxt_blank;
    logic             frame_wrap;
    logic             swap;
    logic             accept;

    scan_timebase #(
        .NUM_COLS     (NUM_COLS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timebase (
        .clk        (clk),
        .rst_n      (rst_n),
        .nxt_idx    (nxt_idx),
        .nxt_blank  (nxt_blank),
        .blank      (blank),
        .frame_wrap (frame_wrap)
    );

    // frame_ready doubles as the inverted shadow-full flag
    assign swap       = frame_wrap && !frame_ready;
    assign accept     = frame_valid && frame_ready;
    assign active_nxt = swap ? shadow_q : active_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= '0;
            shadow_q    <= '0;
            frame_ready <= 1'b1;
            scan_sel    <= BLANK_SEL;
            line_data   <= '0;
            frame_start <= 1'b0;
        end else begin
            active_q <= active_nxt;
            if (swap) begin
                frame_ready <= 1'b1;
            end else if (accept) begin
                shadow_q    <= frame_data;
                frame_ready <= 1'b0;
            end
            scan_sel    <= nxt_blank ? BLANK_SEL : nxt_idx;
            line_data   <= active_nxt[nxt_idx];
            frame_start <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Directed bench for matrix_scan_controller (SCAN_DIV=8, BLANK_CYCLES=2).
module tb_matrix_scan_controller;

    localparam int NC  = 5;
    localparam int NR  = 7;
    localparam int SD  = 8;
    localparam int BC  = 2;
    localparam int FW  = NC * NR;
    localparam int PER = NC * SD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [FW-1:0] frame_data = '0;
    logic          frame_valid = 1'b0;
    logic          frame_ready;
    logic [2:0]    scan_sel;
    logic [NR-1:0] line_data;
    logic          blank;
    logic          frame_start;

    int checks = 0;
    int failures = 0;
    int n = 0;

    logic [FW-1:0] active_m;
    logic [FW-1:0] shadow_m;
    logic          full_m;

    matrix_scan_controller #(
        .NUM_COLS     (NC),
        .NUM_ROWS     (NR),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .scan_sel    (scan_sel),
        .line_data   (line_data),
        .blank       (blank),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n        = 0;
        active_m = '0;
        shadow_m = '0;
        full_m   = 1'b0;
    endtask

    // One clock: advance the reference model, then check every output.
    task automatic tick();
        bit acc;
        bit swp;
        int cnt;
        int col;
        logic [2:0] esel;
        acc = frame_valid && !full_m;
        swp = (n % PER == PER - 1) && full_m;
        @(posedge clk);
        if (swp) begin
            active_m = shadow_m;
            full_m   = 1'b0;
        end else if (acc) begin
            shadow_m = frame_data;
            full_m   = 1'b1;
        end
        n++;
        @(negedge clk);
        cnt  = n % SD;
        col  = (n / SD) % NC;
        esel = (cnt < BC) ? 3'd7 : 3'(col);
        chk("scan_sel", 64'(scan_sel), 64'(esel));
        chk("blank", 64'(blank), 64'(cnt < BC));
        chk("blank_inv", 64'(blank), 64'(scan_sel == 3'b111));
        chk("idx_range", 64'(scan_sel <= 3'd4 || scan_sel == 3'd7), 64'd1);
        chk("line_data", 64'(line_data), 64'(active_m[col*NR +: NR]));
        chk("frame_ready", 64'(frame_ready), 64'(!full_m));
        chk("frame_start", 64'(frame_start), 64'(n > 0 && n % PER == 0));
    endtask

    task automatic goto(input int k);
        while (n % PER != k) tick();
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sel", 64'(scan_sel), 64'h7);
        chk("rst_blank", 64'(blank), 64'h1);
        chk("rst_ready", 64'(frame_ready), 64'h1);
        chk("rst_line", 64'(line_data), 64'h0);
        chk("rst_fstart", 64'(frame_start), 64'h0);
        rst_n = 1'b1;
        model_reset();

        // Scan order over two frames
        repeat (2 * PER) tick();
        goto(8);
        chk("col1_blank_sel", 64'(scan_sel), 64'h7);
        goto(10);
        chk("col1_sel", 64'(scan_sel), 64'h1);
        goto(34);
        chk("col4_sel", 64'(scan_sel), 64'h4);

        // Load column0 = 0x55 mid-frame
        goto(17);
        frame_data  = 35'h55;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        chk("load_ready_drop", 64'(frame_ready), 64'h0);
        chk("load_line_old", 64'(line_data), 64'h0);
        goto(0);
        chk("load_fstart", 64'(frame_start), 64'h1);
        chk("load_line_blank", 64'(line_data), 64'h55);
        chk("load_ready_back", 64'(frame_ready), 64'h1);
        goto(2);
        chk("load_sel0", 64'(scan_sel), 64'h0);
        chk("load_line0", 64'(line_data), 64'h55);
        goto(10);
        chk("load_line1", 64'(line_data), 64'h0);

        // Backpressure: A then B held valid back-to-back
        goto(5);
        frame_data  = {7'h22, 21'h0, 7'h11};
        frame_valid = 1'b1;
        tick();
        chk("bp_a_taken", 64'(frame_ready), 64'h0);
        frame_data = {7'h44, 21'h0, 7'h33};
        goto(39);
        chk("bp_b_waits", 64'(frame_ready), 64'h0);
        tick();
        chk("bp_swap_ready", 64'(frame_ready), 64'h1);
        tick();
        chk("bp_b_taken", 64'(frame_ready), 64'h0);
        frame_valid = 1'b0;
        goto(2);
        chk("bp_a_col0", 64'(line_data), 64'h11);
        goto(34);
        chk("bp_a_col4", 64'(line_data), 64'h22);
        goto(2);
        chk("bp_b_col0", 64'(line_data), 64'h33);
        goto(34);
        chk("bp_b_col4", 64'(line_data), 64'h44);

        // Collision: valid high on the swap edge with shadow full
        goto(20);
        frame_data  = 35'h66;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        goto(39);
        frame_data  = 35'h0f;
        frame_valid = 1'b1;
        tick();
        chk("col_swap_ready", 64'(frame_ready), 64'h1);
        chk("col_c_line", 64'(line_data), 64'h66);
        tick();
        chk("col_d_taken", 64'(frame_ready), 64'h0);
        frame_valid = 1'b0;
        goto(2);
        chk("col_c_col0", 64'(line_data), 64'h66);
        goto(0);
        goto(2);
        chk("col_d_col0", 64'(line_data), 64'h0f);

        // Random frames and random valid
        for (int i = 0; i < 400; i++) begin
            frame_data  = FW'({$urandom, $urandom});
            frame_valid = 1'($urandom_range(0, 1));
            tick();
        end
        frame_valid = 1'b0;

        // Reset mid-scan with a frame pending in the shadow
        for (int i = 0; i < 2 * PER && full_m; i++) tick();
        frame_data  = '1;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        goto(0);
        goto(13);
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        chk("pre_rst_line", 64'(line_data), 64'h7f);
        chk("pre_rst_ready", 64'(frame_ready), 64'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", 64'(scan_sel), 64'h7);
        chk("mid_rst_blank", 64'(blank), 64'h1);
        chk("mid_rst_ready", 64'(frame_ready), 64'h1);
        chk("mid_rst_line", 64'(line_data), 64'h0);
        chk("mid_rst_fstart", 64'(frame_start), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (PER + 5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
